cpc_ram_ctrl: RTL and testbench

//  Banking controller implemented in the xc9572 CPLD. Sits between the CPC expansion bus and the
//  512K SRAM. Snoops Gate Array RAM-config writes (OUT &7Fxx, D7:D6=11) into a config register.

---
 rtl/cpc_ram_pkg.sv | 40 ++++
 rtl/cpc_ram_ctrl_if.sv | 29 ++
 rtl/cpc_bank_map.sv | 17 +
 rtl/cpc_ram_ctrl.sv | 75 +++++++
 tb/tb_cpc_ram_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/cpc_ram_pkg.sv
// Shared types and constants for the CPC expansion RAM banking controller.
// The block map turns a Gate Array RAM config and a Z80 16K block into an SRAM block select.
package cpc_ram_pkg;

    typedef logic [2:0] cfg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // D[7:6] value that selects the Gate Array RAM-config function
    localparam logic [1:0] GA_PORT_SEL = 2'b11;

    typedef struct packed {
        logic       hit;
        logic [1:0] blk;
    } map_t;

    localparam map_t M_I  = '{hit: 1'b0, blk: 2'd0};
    localparam map_t M_X0 = '{hit: 1'b1, blk: 2'd0};
    localparam map_t M_X1 = '{hit: 1'b1, blk: 2'd1};
    localparam map_t M_X2 = '{hit: 1'b1, blk: 2'd2};
    localparam map_t M_X3 = '{hit: 1'b1, blk: 2'd3};

    // cfg3 maps Z80 block 3 to expansion block 3; its block 1 would be internal block 3,
    // which cannot be remapped from outside, so block 1 is left on internal RAM.
    localparam map_t BANK_MAP [8][4] = '{
        '{M_I,  M_I,  M_I,  M_I },
        '{M_I,  M_I,  M_I,  M_X3},
        '{M_X0, M_X1, M_X2, M_X3},
        '{M_I,  M_I,  M_I,  M_X3},
        '{M_I,  M_X0, M_I,  M_I },
        '{M_I,  M_X1, M_I,  M_I },
        '{M_I,  M_X2, M_I,  M_I },
        '{M_I,  M_X3, M_I,  M_I }
    };

endpackage

// File: rtl/cpc_ram_ctrl_if.sv
// CPC expansion bus and SRAM control signals seen by the banking controller.
// Bus signals come in on the slave side; the bench or the CPC bus acts as master.
interface cpc_ram_ctrl_if #(
    parameter int BANK_BITS = 3
);
    logic                 MREQ_B;
    logic                 IOREQ_B;
    logic                 RD_B;
    logic                 WR_B;
    logic                 RAMRD_B;
    logic                 A15;
    logic                 A14;
    logic [7:0]           D;
    logic                 RAMCS_B;
    logic                 RAMOE_B;
    logic                 RAMWE_B;
    logic [BANK_BITS+1:0] HIADR;
    logic                 RAMDIS;

    modport master (
        output MREQ_B, IOREQ_B, RD_B, WR_B, RAMRD_B, A15, A14, D,
        input  RAMCS_B, RAMOE_B, RAMWE_B, HIADR, RAMDIS
    );

    modport slave (
        input  MREQ_B, IOREQ_B, RD_B, WR_B, RAMRD_B, A15, A14, D,
        output RAMCS_B, RAMOE_B, RAMWE_B, HIADR, RAMDIS
    );
endinterface

// File: rtl/cpc_bank_map.sv
// Combinational lookup: RAM config plus Z80 block (A15:A14) -> expansion hit and SRAM block.
module cpc_bank_map
    import cpc_ram_pkg::*;
(
    input  cfg_t       cfg_i,
    input  logic [1:0] blk_i,
    output logic       hit_o,
    output logic [1:0] blk_o
);
    map_t entry;

    always_comb begin
        entry = BANK_MAP[cfg_i][blk_i];
        hit_o = entry.hit;
        blk_o = entry.blk;
    end
endmodule

// File: rtl/cpc_ram_ctrl.sv
// Snoops Gate Array RAM-config writes and drives the 512K SRAM strobes, HIADR and RAMDIS.
// The capture FSM latches D once per IO write; memory outputs are combinational.
module cpc_ram_ctrl
    import cpc_ram_pkg::*;
#(
    parameter int BANK_BITS  = 3,
    parameter int DECODE_A14 = 1
) (
    input  logic           CLK,
    input  logic           RESET,
    cpc_ram_ctrl_if.slave  bus,
    output state_t         dbg_state_o
);
    state_t                state_q, state_d;
    cfg_t                  cfg_q, cfg_d;
    logic [BANK_BITS-1:0]  bank_q, bank_d;
    logic                  iowr;
    logic                  map_hit;
    logic [1:0]            map_blk;
    logic                  act;
    logic                  rd_en;

    assign iowr = !bus.IOREQ_B && !bus.WR_B && !bus.A15 && (bus.A14 || (DECODE_A14 == 0));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= HOLD;
            cfg_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            bank_q  <= bank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (iowr) begin
                    state_d = CAPT;
                    if (bus.D[7:6] == GA_PORT_SEL) begin
                        cfg_d  = bus.D[2:0];
                        bank_d = bus.D[3 +: BANK_BITS];
                    end
                end
            end
            CAPT:    state_d = HOLD;
            HOLD:    if (!iowr) state_d = IDLE;
            default: state_d = HOLD;
        endcase
    end

    assign dbg_state_o = state_q;

    cpc_bank_map u_map (
        .cfg_i (cfg_q),
        .blk_i ({bus.A15, bus.A14}),
        .hit_o (map_hit),
        .blk_o (map_blk)
    );

    // RESET gating keeps the SRAM quiet even while the bus is mid-cycle.
    assign act   = map_hit && !bus.MREQ_B && !RESET;
    assign rd_en = !bus.RD_B && !bus.RAMRD_B;

    assign bus.RAMCS_B = !act;
    assign bus.RAMOE_B = !(act && rd_en && bus.WR_B);
    assign bus.RAMWE_B = !(act && !bus.WR_B && bus.RD_B);
    assign bus.RAMDIS  = act && (!bus.WR_B || rd_en);
    assign bus.HIADR   = (map_hit && !RESET) ? {bank_q, map_blk} : '0;
endmodule

// File: tb/tb_cpc_ram_ctrl.sv
// Directed bench for cpc_ram_ctrl: config capture, block map, strobe rules and reset behaviour.
module tb_cpc_ram_ctrl;
    import cpc_ram_pkg::*;

    logic   CLK = 1'b0;
    logic   RESET;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;

    // {RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS}
    localparam logic [3:0] NONE   = 4'b1110;
    localparam logic [3:0] RD_HIT = 4'b0011;
    localparam logic [3:0] WR_HIT = 4'b0101;
    localparam logic [3:0] ROM_RD = 4'b0110;
    localparam logic [3:0] BOTH   = 4'b0111;

    cpc_ram_ctrl_if #(.BANK_BITS(3)) bus ();

    cpc_ram_ctrl #(.BANK_BITS(3), .DECODE_A14(1)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.MREQ_B = 1'b1; bus.IOREQ_B = 1'b1; bus.RD_B = 1'b1; bus.WR_B = 1'b1;
        bus.RAMRD_B = 1'b1; bus.A15 = 1'b0; bus.A14 = 1'b0; bus.D = 8'h00;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.RAMCS_B, bus.RAMOE_B, bus.RAMWE_B, bus.RAMDIS, bus.HIADR});
    endfunction

    // One memory access at block blk, checked 1ns after the bus settles.
    task automatic mem(input string tag, input logic [1:0] blk, input logic rd_b,
                       input logic wr_b, input logic ramrd_b, input logic [8:0] exp);
        bus.MREQ_B = 1'b0; bus.A15 = blk[1]; bus.A14 = blk[0];
        bus.RD_B = rd_b; bus.WR_B = wr_b; bus.RAMRD_B = ramrd_b;
        #1;
        chk(tag, outs(), 32'(exp));
        bus_idle();
    endtask

    task automatic io_out(input logic a14, input logic [7:0] d);
        @(negedge CLK);
        bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0; bus.A15 = 1'b0; bus.A14 = a14; bus.D = d;
        @(negedge CLK);
        bus_idle();
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        bus_idle();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // 1: reset state and cfg0
        chk("rst_state", 32'(dbg_state), 32'(HOLD));
        mem("rst_read_c000", 2'b11, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});
        RESET = 1'b0;
        mem("cfg0_read_c000", 2'b11, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});
        @(negedge CLK);
        chk("idle_after_rst", 32'(dbg_state), 32'(IDLE));

        // 2: OUT &7F00,&C2 with FSM walk
        bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0; bus.A14 = 1'b1; bus.D = 8'hC2;
        @(posedge CLK); #1;
        chk("state_capt", 32'(dbg_state), 32'(CAPT));
        @(negedge CLK);
        bus_idle();
        @(posedge CLK); #1;
        chk("state_hold", 32'(dbg_state), 32'(HOLD));
        @(posedge CLK); #1;
        chk("state_idle", 32'(dbg_state), 32'(IDLE));
        @(negedge CLK);
        mem("cfg2_read_0000", 2'b00, 1'b0, 1'b1, 1'b0, {RD_HIT, 5'b00000});
        @(negedge CLK);
        mem("cfg2_read_c000", 2'b11, 1'b0, 1'b1, 1'b0, {RD_HIT, 5'b00011});

        // 3: OUT &FF -> bank7 cfg7
        io_out(1'b1, 8'hFF);
        mem("cfg7_read_4000", 2'b01, 1'b0, 1'b1, 1'b0, {RD_HIT, 5'b11111});
        @(negedge CLK);
        mem("cfg7_read_8000", 2'b10, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});
        @(negedge CLK);
        mem("cfg7_rd_wr_both", 2'b01, 1'b0, 1'b0, 1'b0, {BOTH, 5'b11111});

        // 4: OUT &C3
        io_out(1'b1, 8'hC3);
        mem("cfg3_read_4000", 2'b01, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});
        @(negedge CLK);
        mem("cfg3_write_c000", 2'b11, 1'b1, 1'b0, 1'b1, {WR_HIT, 5'b00011});
        @(negedge CLK);
        mem("cfg3_rom_read_c000", 2'b11, 1'b0, 1'b1, 1'b1, {ROM_RD, 5'b00011});

        // 5: ignored writes, then a long strobe
        io_out(1'b1, 8'h82);
        mem("d82_ignored", 2'b00, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});
        io_out(1'b0, 8'hC2);
        mem("port3f_ignored", 2'b00, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});
        @(negedge CLK);
        bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0; bus.A14 = 1'b1; bus.D = 8'hC4;
        @(negedge CLK);
        bus.D = 8'hC7;
        @(posedge CLK); #1;
        chk("long_strobe_hold", 32'(dbg_state), 32'(HOLD));
        repeat (2) @(negedge CLK);
        bus_idle();
        repeat (2) @(negedge CLK);
        mem("cfg4_read_4000", 2'b01, 1'b0, 1'b1, 1'b0, {RD_HIT, 5'b00000});
        @(negedge CLK);
        mem("cfg4_read_c000", 2'b11, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});

        // 6: reset mid-OUT, released with the strobe still low
        @(negedge CLK);
        bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0; bus.A14 = 1'b1; bus.D = 8'hC5;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_mid_out_state", 32'(dbg_state), 32'(HOLD));
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        chk("held_after_rst", 32'(dbg_state), 32'(HOLD));
        bus_idle();
        repeat (2) @(negedge CLK);
        chk("idle_after_release", 32'(dbg_state), 32'(IDLE));
        mem("no_capture_4000", 2'b01, 1'b0, 1'b1, 1'b0, {NONE, 5'b00000});
        io_out(1'b1, 8'hC5);
        mem("cfg5_read_4000", 2'b01, 1'b0, 1'b1, 1'b0, {RD_HIT, 5'b00001});

        // HIADR tracks the map even with MREQ inactive; strobes do not
        @(negedge CLK);
        bus.A14 = 1'b1;
        #1;
        chk("no_mreq_hiadr", outs(), 32'({NONE, 5'b00001}));
        bus_idle();

        // async reset forces outputs idle during an active hit
        @(negedge CLK);
        bus.MREQ_B = 1'b0; bus.RD_B = 1'b0; bus.RAMRD_B = 1'b0; bus.A14 = 1'b1;
        #1;
        chk("pre_rst_hit", outs(), 32'({RD_HIT, 5'b00001}));
        RESET = 1'b1;
        #1;
        chk("rst_forces_idle", outs(), 32'({NONE, 5'b00000}));
        bus_idle();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
